gpio_ctrl: RTL and testbench

- Memory-mapped GPIO output controller between the riscv core's peripheral bus and the board GPIO pins (LEDs).
- Holds the pin data register and provides atomic SET/CLR access.
- Runs a per-pin 8-bit PWM scheduler so LEDs can be dimmed without CPU involvement.
- Lets the core own the pins through a single valid/ready slave port.

---
 rtl/gpio_ctrl_if.sv | 15 +
 rtl/gpio_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gpio_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_if.sv
// Peripheral bus port between the core and gpio_ctrl.
// Single valid/ready request; read data is returned while ready is high.
interface gpio_ctrl_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [5:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_valid, bus_we, bus_addr, bus_wdata,
                    input  bus_ready, bus_rdata);
    modport slave  (input  bus_valid, bus_we, bus_addr, bus_wdata,
                    output bus_ready, bus_rdata);
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO output controller: DATA/SET/CLR pin register with an optional per-pin 8-bit PWM dimmer.
// Define GPIO_CTRL_PWM_EN to build MODE/DUTY, the prescaler and pwm_cnt; otherwise gpio is registered DATA.

`ifdef GPIO_CTRL_PWM_EN
module gpio_ctrl_pin (
    input  logic       clk,
    input  logic       rst,
    input  logic       duty_we,
    input  logic [7:0] duty_wdata,
    input  logic       boundary,
    input  logic [7:0] pwm_cnt,
    input  logic       data,
    input  logic       mode,
    output logic [7:0] duty,
    output logic       pin_d
);
    logic [7:0] duty_q, duty_d;
    logic [7:0] shadow_q, shadow_d;

    always_comb begin
        duty_d   = duty_we ? duty_wdata : duty_q;
        // Shadow takes the pre-write value, so a write on the boundary edge waits a full period.
        shadow_d = boundary ? duty_q : shadow_q;
        pin_d    = mode ? (data & (pwm_cnt < shadow_q)) : data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            shadow_q <= '0;
        end else begin
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
        end
    end

    assign duty = duty_q;
endmodule
`endif

module gpio_ctrl #(
    parameter int N_GPIO   = 8,
    parameter int PRESCALE = 47
) (
    input  logic              clk,
    input  logic              rst,
    gpio_ctrl_if.slave        bus,
    output logic [N_GPIO-1:0] gpio
);
    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              access, wr_en, rd_en, ready;
    logic [3:0]        widx;
    logic [N_GPIO-1:0] wbits;
    logic [N_GPIO-1:0] data_q, data_d;
    logic [N_GPIO-1:0] gpio_q, gpio_d;
    logic [31:0]       rdata_q, rdata_d, rd_val;
    logic              unused_bits;

    assign widx        = bus.bus_addr[5:2];
    assign wbits       = bus.bus_wdata[N_GPIO-1:0];
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.bus_valid) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requests are only sampled in IDLE; valid held through ACK is ignored.
    always_comb begin
        access = (state_q == IDLE) && bus.bus_valid;
        wr_en  = access && bus.bus_we;
        rd_en  = access && !bus.bus_we;
        ready  = (state_q == ACK);
    end

    assign bus.bus_ready = ready;
    assign bus.bus_rdata = rdata_q;

    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (widx)
                4'd0:    data_d = wbits;
                4'd1:    data_d = data_q | wbits;
                4'd2:    data_d = data_q & ~wbits;
                default: data_d = data_q;
            endcase
        end
    end

`ifdef GPIO_CTRL_PWM_EN
    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    logic [PW-1:0]           pre_q, pre_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [N_GPIO-1:0]       mode_q, mode_d;
    logic [N_GPIO-1:0]       pin_d;
    logic [N_GPIO-1:0][7:0]  duty;
    logic                    tick, boundary;

    always_comb begin
        tick     = (pre_q == PW'(PRESCALE));
        pre_d    = tick ? '0 : pre_q + PW'(1);
        cnt_d    = tick ? cnt_q + 8'd1 : cnt_q;
        boundary = tick && (cnt_q == 8'hFF);
        mode_d   = (wr_en && widx == 4'd3) ? wbits : mode_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        gpio_ctrl_pin u_pin (
            .clk        (clk),
            .rst        (rst),
            .duty_we    (wr_en && widx == 4'(4 + i)),
            .duty_wdata (bus.bus_wdata[7:0]),
            .boundary   (boundary),
            .pwm_cnt    (cnt_q),
            .data       (data_q[i]),
            .mode       (mode_q[i]),
            .duty       (duty[i]),
            .pin_d      (pin_d[i])
        );
    end

    assign gpio_d = pin_d;
`else
    assign gpio_d = data_q;
`endif

    always_comb begin
        rd_val = '0;
        if (widx <= 4'd2) rd_val[N_GPIO-1:0] = data_q;
`ifdef GPIO_CTRL_PWM_EN
        if (widx == 4'd3) rd_val[N_GPIO-1:0] = mode_q;
        for (int i = 0; i < N_GPIO; i++) begin
            if (widx == 4'(4 + i)) rd_val[7:0] = duty[i];
        end
`endif
        rdata_d = rd_en ? rd_val : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            gpio_q  <= '0;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            gpio_q  <= gpio_d;
            rdata_q <= rdata_d;
        end
    end

    assign gpio = gpio_q;
endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: a time-indexed reference model predicts acks, read data and pins;
// a negedge monitor compares them against the DUT.
module tb_gpio_ctrl;
    localparam int N_GPIO   = 8;
    localparam int PRESCALE = 0;
`ifdef GPIO_CTRL_PWM_EN
    localparam bit PWM_EN = 1'b1;
`else
    localparam bit PWM_EN = 1'b0;
`endif

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_GPIO-1:0] gpio;

    gpio_ctrl_if bus ();

    gpio_ctrl #(.N_GPIO(N_GPIO), .PRESCALE(PRESCALE)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .gpio (gpio)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    sb_t sb_q[$];

    // Reference model state
    logic [N_GPIO-1:0] m_data   = '0;
    logic [N_GPIO-1:0] m_mode   = '0;
    logic [N_GPIO-1:0] m_gpio   = '0;
    logic [7:0]        m_duty   [N_GPIO];
    logic [7:0]        m_shadow [N_GPIO];
    longint            m_cyc    = 0;
    bit                m_ack    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: PWM count is (edges since reset)/(PRESCALE+1) mod 256; each period uses the DUTY
    // value present just before its first edge; one bus access per request, then one ack cycle.
    initial begin : model
        int          cnt, w;
        bit          tick;
        logic [N_GPIO-1:0] nxt;
        logic [31:0] rv;
        for (int i = 0; i < N_GPIO; i++) begin
            m_duty[i] = 8'd0;
            m_shadow[i] = 8'd0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_data = '0; m_mode = '0; m_gpio = '0; m_cyc = 0; m_ack = 1'b0;
                for (int i = 0; i < N_GPIO; i++) begin
                    m_duty[i] = 8'd0;
                    m_shadow[i] = 8'd0;
                end
                sb_q.delete();
            end else begin
                cnt  = int'((m_cyc / (PRESCALE + 1)) % 256);
                tick = (m_cyc % (PRESCALE + 1)) == PRESCALE;
                for (int i = 0; i < N_GPIO; i++)
                    nxt[i] = m_data[i] & (!(PWM_EN && m_mode[i]) || (cnt < int'(m_shadow[i])));
                if (PWM_EN && tick && cnt == 255) m_shadow = m_duty;
                m_cyc++;
                if (m_ack) begin
                    m_ack = 1'b0;
                end else if (bus.bus_valid) begin
                    m_ack = 1'b1;
                    w = int'(bus.bus_addr[5:2]);
                    if (bus.bus_we) begin
                        if (w == 0) m_data = bus.bus_wdata[N_GPIO-1:0];
                        else if (w == 1) m_data = m_data | bus.bus_wdata[N_GPIO-1:0];
                        else if (w == 2) m_data = m_data & ~bus.bus_wdata[N_GPIO-1:0];
                        else if (PWM_EN && w == 3) m_mode = bus.bus_wdata[N_GPIO-1:0];
                        else if (PWM_EN && w >= 4 && w < 4 + N_GPIO) m_duty[w-4] = bus.bus_wdata[7:0];
                        sb_q.push_back('{is_rd: 1'b0, rdata: 32'd0});
                    end else begin
                        rv = 32'd0;
                        if (w <= 2) rv[N_GPIO-1:0] = m_data;
                        else if (PWM_EN && w == 3) rv[N_GPIO-1:0] = m_mode;
                        else if (PWM_EN && w >= 4 && w < 4 + N_GPIO) rv[7:0] = m_duty[w-4];
                        sb_q.push_back('{is_rd: 1'b1, rdata: rv});
                    end
                end
                m_gpio = nxt;
            end
        end
    end

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("gpio", 32'(gpio), 32'(m_gpio));
                chk("bus_ready", 32'(bus.bus_ready), 32'(m_ack));
                if (bus.bus_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_ack: got ack with no pending request at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.is_rd) chk("rdata", bus.bus_rdata, e.rdata);
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.bus_ready && t < 20);
        if (!bus.bus_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: got no bus_ready within 20 cycles, expected one at %0t", $time);
        end
    endtask

    task automatic access(input bit we, input logic [5:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        bus.bus_valid = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        wait_ready();
        bus.bus_valid = 1'b0;
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (256) begin
            @(negedge clk);
            hi += int'(gpio[0]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        int hi;
        int w;
        logic [5:0] a;
        bus.bus_valid = 1'b0; bus.bus_we = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_gpio", 32'(gpio), 32'd0);
        chk("reset_ready", 32'(bus.bus_ready), 32'd0);
        chk("reset_rdata", bus.bus_rdata, 32'd0);
        rst = 1'b0;

        // DATA write latency and readback
        access(1'b1, 6'h00, 32'h0000_00A5);
        chk("gpio_before_update", 32'(gpio), 32'h00);
        @(negedge clk);
        chk("gpio_after_data_wr", 32'(gpio), 32'hA5);
        access(1'b0, 6'h00, 32'h0);

        // SET / CLR and their readbacks
        access(1'b1, 6'h04, 32'h0000_000F);
        access(1'b0, 6'h04, 32'h0);
        access(1'b1, 6'h08, 32'h0000_0081);
        access(1'b0, 6'h08, 32'h0);
        @(negedge clk);
        chk("gpio_after_set_clr", 32'(gpio), 32'h2E);

        // Unmapped address
        access(1'b1, 6'h3C, 32'hFFFF_FFFF);
        access(1'b0, 6'h3C, 32'h0);
        access(1'b0, 6'h01, 32'h0);

        // Asynchronous reset while a read is being acknowledged
        @(negedge clk);
        bus.bus_valid = 1'b1; bus.bus_we = 1'b0; bus.bus_addr = 6'h00;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midack_rst_ready", 32'(bus.bus_ready), 32'd0);
        chk("midack_rst_gpio", 32'(gpio), 32'd0);
        chk("midack_rst_rdata", bus.bus_rdata, 32'd0);
        bus.bus_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        access(1'b0, 6'h00, 32'h0);

        // PWM dimming on pin 0
        access(1'b1, 6'h0C, 32'h01);
        access(1'b1, 6'h00, 32'h01);
        access(1'b1, 6'h10, 32'd64);
        access(1'b0, 6'h10, 32'h0);
        repeat (300) @(negedge clk);
        count_high(hi);
        chk("pwm_duty64_high", 32'(hi), PWM_EN ? 32'd64 : 32'd256);
        repeat (37) @(negedge clk);
        access(1'b1, 6'h10, 32'd0);
        repeat (520) @(negedge clk);
        count_high(hi);
        chk("pwm_duty0_high", 32'(hi), PWM_EN ? 32'd0 : 32'd256);
        access(1'b1, 6'h10, 32'd200);
        repeat (300) @(negedge clk);
        count_high(hi);
        chk("pwm_duty200_high", 32'(hi), PWM_EN ? 32'd200 : 32'd256);
        access(1'b0, 6'h0C, 32'h0);

        // valid held high: alternating SET/CLR of bit 0
        access(1'b1, 6'h0C, 32'h0);
        access(1'b1, 6'h00, 32'h0);
        @(negedge clk);
        bus.bus_valid = 1'b1; bus.bus_we = 1'b1; bus.bus_wdata = 32'h1;
        for (int k = 0; k < 10; k++) begin
            bus.bus_addr = (k % 2 == 0) ? 6'h04 : 6'h08;
            wait_ready();
        end
        bus.bus_addr = 6'h04;
        for (int k = 0; k < 4; k++) wait_ready();
        bus.bus_valid = 1'b0;
        access(1'b0, 6'h00, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            w = int'($urandom_range(0, 15));
            a = {4'(w), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
